dram_burst_reader: RTL and testbench
====================================

# dram_burst_reader

Read-side master for the byte-wide, single-port DRAM model. It accepts a burst request of start address and word count, issues one byte read per cycle to the memory port, and accounts for the memory's 1-cycle registered read latency. Returned bytes are packed little-endian into WORD_BYTES-wide words and delivered on a valid/ready stream to the accelerator datapath (weight and activation loaders).

## Interface
- ADDR_WIDTH, 24: memory byte-address width; must match the memory instance.
- DATA_WIDTH, 8: memory data width (one byte).
- WORD_BYTES, 4: bytes packed per output word; ≥2.
- LEN_WIDTH, 16: width of the burst length field, counted in words.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  burst request valid.
- req_ready  out  1  high only in IDLE.
- req_addr  in  ADDR_WIDTH  start byte address.
- req_len  in  LEN_WIDTH  number of words to read; 0 is legal.
- out_valid  out  1  packed word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WORD_BYTES*DATA_WIDTH  packed word; lowest address in bits [7:0].
- done  out  1  one-cycle pulse when the burst has completed.
- busy  out  1  high in BUSY.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_we  out  1  constant 0.
- mem_din  out  DATA_WIDTH  constant 0.
- mem_dout  in  DATA_WIDTH  memory read data, valid the cycle after the address is issued.

## Operation
- Reset values: req_ready=1, out_valid=0, out_data=0, done=0, busy=0, mem_addr=0. All counters and the pack register clear. Reset mid-burst abandons the burst, and any in-flight byte is discarded.
- States:
  - IDLE to BUSY on req_valid&&req_ready with req_len≠0. The handshake latches cur_addr=req_addr and words_left=req_len, and sets bytes_to_issue=req_len*WORD_BYTES, computed at LEN_WIDTH+clog2(WORD_BYTES) bits.
  - IDLE with req_len=0: stay in IDLE and pulse done the next cycle. No memory access.
  - BUSY to IDLE when the final word handshakes (out_valid&&out_ready with words_left==1). done is registered high in the following cycle.
- Issue rule, evaluated each BUSY cycle on registered values: issue when bytes_to_issue>0 and pack_count+inflight<WORD_BYTES.
  - On issue: mem_addr=cur_addr, cur_addr+1, bytes_to_issue−1, inflight=1 for the next cycle.
  - cur_addr wraps modulo 2^ADDR_WIDTH (0xFFFFFF+1 = 0x000000).
- Capture: in the cycle after an issue, mem_dout is written into pack byte lane pack_count, and pack_count increments.
- Transfer: when pack_count==WORD_BYTES and (!out_valid || out_ready), the pack register moves to out_data, out_valid is set, and pack_count clears.
- Backpressure: out_valid/out_data hold stable until accepted. Issue stalls naturally because the pack register is full. No byte is ever dropped or re-read.
- Requests presented while busy are ignored (req_ready=0).

## Timing
- The request handshake happens in cycle 0. The first memory issue is in cycle 1.
- With out_ready held high, the first out_valid appears in cycle WORD_BYTES+3.
- Steady state with out_ready held high: one word every WORD_BYTES+2 cycles.
- done rises exactly 1 cycle after the last output handshake and lasts 1 cycle. busy falls in the same cycle that done rises.
- mem_addr holds its last value when not issuing.

## Structure
- Package dram_pkg holds:
  - default ADDR_WIDTH/DATA_WIDTH constants shared with the memory model;
  - the state enum {IDLE, BUSY}.
- Sub-module byte_packer holds the pack register, pack_count, the output register, and the valid/ready transfer logic.
- The top level holds the FSM, the address and length counters, the issue rule, and the inflight flag.

## Test plan
- Memory preloaded with bytes 0x00..0x0F at addresses 0..15; request addr=0, len=2, out_ready=1 -> 0x03020100 in cycle 7, 0x07060504 in cycle 13, done in cycle 14.
- Same preload; request addr=0, len=4; out_ready toggled randomly -> words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C in order; out_data stable while stalled; exactly 16 reads issued.
- Request addr=0xFFFFFE, len=1 -> issued addresses FFFFFE, FFFFFF, 000000, 000001; word assembled from those bytes.
- Request len=0 -> done the next cycle, no mem_addr change, busy stays 0.
- Assert rst in the middle of a len=4 burst, then request addr=4, len=1 -> all outputs at reset values after reset; then a single word 0x07060504 and one done pulse.
- req_valid held high during BUSY -> second request not accepted until IDLE; mem_we=0 throughout.

Source files
------------

// File: rtl/dram_pkg.sv
// dram_pkg: constants shared with the byte-wide DRAM model and the burst reader state type
package dram_pkg;
    localparam int DRAM_ADDR_WIDTH = 24;
    localparam int DRAM_DATA_WIDTH = 8;
    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: packs captured bytes little-endian into words held on a valid/ready output
//   cap_i, byte_i   : byte written into lane pack_count_o when cap_i is high
//   out_ready_i     : consumer accepts out_data_o
//   out_valid_o     : registered word valid, held until accepted
//   out_data_o      : registered packed word, lowest address in the low byte
//   pack_count_o    : bytes currently held in the pack register
module byte_packer import dram_pkg::*; #(
    parameter int DATA_WIDTH = DRAM_DATA_WIDTH,
    parameter int WORD_BYTES = 4,
    localparam int CW = $clog2(WORD_BYTES) + 1,
    localparam int WW = WORD_BYTES * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cap_i,
    input  logic [DATA_WIDTH-1:0] byte_i,
    input  logic                  out_ready_i,
    output logic                  out_valid_o,
    output logic [WW-1:0]         out_data_o,
    output logic [CW-1:0]         pack_count_o
);
    logic [WW-1:0] pack_q;
    logic [WW-1:0] data_q;
    logic [CW-1:0] count_q;
    logic          valid_q;
    logic          xfer;

    // a full pack register moves out only when the output slot is free or being emptied
    assign xfer = count_q == CW'(WORD_BYTES) && (!valid_q || out_ready_i);
    assign out_valid_o = valid_q;
    assign out_data_o = data_q;
    assign pack_count_o = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pack_q <= '0;
            data_q <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            if (cap_i) begin
                pack_q[int'(count_q) * DATA_WIDTH +: DATA_WIDTH] <= byte_i;
                count_q <= count_q + CW'(1);
            end
            if (xfer) begin
                data_q <= pack_q;
                valid_q <= 1'b1;
                count_q <= '0;
            end else if (out_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/dram_burst_reader.sv
// dram_burst_reader: issues byte reads for a word burst and streams packed words out
//   req_valid/req_ready/req_addr/req_len : burst request, accepted only in IDLE
//   out_valid/out_ready/out_data         : packed word stream
//   done                                 : one-cycle pulse after a burst completes
//   busy                                 : burst in progress
//   mem_addr/mem_we/mem_din/mem_dout     : read-only port to the DRAM model (1-cycle read latency)
module dram_burst_reader import dram_pkg::*; #(
    parameter int ADDR_WIDTH = DRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DRAM_DATA_WIDTH,
    parameter int WORD_BYTES = 4,
    parameter int LEN_WIDTH  = 16,
    localparam int CW = $clog2(WORD_BYTES) + 1,
    localparam int BW = LEN_WIDTH + $clog2(WORD_BYTES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    input  logic [LEN_WIDTH-1:0]           req_len,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WORD_BYTES*DATA_WIDTH-1:0] out_data,
    output logic                           done,
    output logic                           busy,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic                           mem_we,
    output logic [DATA_WIDTH-1:0]          mem_din,
    input  logic [DATA_WIDTH-1:0]          mem_dout
);
    state_t                state_q;
    logic [ADDR_WIDTH-1:0] cur_addr_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [LEN_WIDTH-1:0]  words_left_q;
    logic [BW-1:0]         bytes_q;
    logic                  inflight_q;
    logic                  done_q;
    logic [CW-1:0]         pack_count;
    logic                  issue;

    // never request more bytes than the pack register can still take, counting the one in flight
    assign issue = state_q == BUSY && bytes_q != '0 && (pack_count + CW'(inflight_q)) < CW'(WORD_BYTES);
    assign mem_addr = issue ? cur_addr_q : mem_addr_q;
    assign mem_we = 1'b0;
    assign mem_din = '0;
    assign req_ready = state_q == IDLE;
    assign busy = state_q == BUSY;
    assign done = done_q;

    byte_packer #(.DATA_WIDTH(DATA_WIDTH), .WORD_BYTES(WORD_BYTES)) u_packer (
        .clk(clk),
        .rst(rst),
        .cap_i(inflight_q),
        .byte_i(mem_dout),
        .out_ready_i(out_ready),
        .out_valid_o(out_valid),
        .out_data_o(out_data),
        .pack_count_o(pack_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_addr_q <= '0;
            mem_addr_q <= '0;
            words_left_q <= '0;
            bytes_q <= '0;
            inflight_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            inflight_q <= issue;
            if (issue) begin
                mem_addr_q <= cur_addr_q;
                cur_addr_q <= cur_addr_q + ADDR_WIDTH'(1);
                bytes_q <= bytes_q - BW'(1);
            end
            if (state_q == IDLE && req_valid) begin
                if (req_len == '0) begin
                    done_q <= 1'b1;
                end else begin
                    state_q <= BUSY;
                    cur_addr_q <= req_addr;
                    words_left_q <= req_len;
                    bytes_q <= BW'(req_len) * BW'(WORD_BYTES);
                end
            end else if (state_q == BUSY && out_valid && out_ready) begin
                words_left_q <= words_left_q - LEN_WIDTH'(1);
                if (words_left_q == LEN_WIDTH'(1)) begin
                    state_q <= IDLE;
                    done_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dram_burst_reader.sv
// tb_dram_burst_reader: directed vector table plus hand-written timing, reset and overlap sequences
module tb_dram_burst_reader;
    localparam int AW = 24;
    localparam int LW = 16;

    typedef struct {
        logic [AW-1:0]      addr;
        logic [LW-1:0]      len;
        logic [15:0]        rmask;
        logic [3:0][31:0]   w;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic          req_ready, out_valid, done, busy, mem_we;
    logic [31:0]   out_data;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout = '0;
    int            tests = 0;
    int            fails = 0;
    int            side_bad = 0;

    always #5 clk = ~clk;

    dram_burst_reader dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .done(done), .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // memory: 0x00..0x0F at 0..15, other addresses hold addr[7:0]^0xE0
    function automatic logic [7:0] byte_at(input logic [AW-1:0] a);
        return a < 16 ? a[7:0] : (8'hE0 ^ a[7:0]);
    endfunction

    always @(posedge clk) mem_dout <= byte_at(mem_addr);

    always @(negedge clk) if (mem_we !== 1'b0 || mem_din !== 8'h00) side_bad++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " req_ready"}, req_ready, 1);
        check({tag, " out_valid"}, out_valid, 0);
        check({tag, " out_data"}, out_data, 0);
        check({tag, " done"}, done, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " mem_addr"}, mem_addr, 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int nacc = 0;
        int nrd = 0;
        int cyc = 0;
        int addr_bad = 0;
        int stab_bad = 0;
        bit fin = 0;
        logic pv = 0;
        logic [31:0] pd = '0;
        logic [AW-1:0] last_addr;
        logic [AW-1:0] ea;
        logic [3:0][31:0] got = '0;
        last_addr = mem_addr;
        check({tag, " req_ready idle"}, req_ready, 1);
        req_addr = v.addr;
        req_len = v.len;
        req_valid = 1'b1;
        out_ready = v.rmask[0];
        while (!fin && cyc < 400) begin
            step();
            cyc++;
            req_valid = 1'b0;
            if (mem_addr !== last_addr) begin
                ea = v.addr + AW'(nrd);
                if (mem_addr !== ea) addr_bad++;
                nrd++;
                last_addr = mem_addr;
            end
            if (pv && !(out_valid === 1'b1 && out_data === pd)) stab_bad++;
            out_ready = v.rmask[cyc % 16];
            if (out_valid && out_ready) begin
                if (nacc < 4) got[nacc] = out_data;
                nacc++;
            end
            pv = out_valid && !out_ready;
            pd = out_data;
            if (done) fin = 1;
        end
        check({tag, " done seen"}, fin, 1);
        check({tag, " word count"}, nacc, v.len);
        for (int i = 0; i < 4 && i < int'(v.len); i++) check({tag, " word"}, got[i], v.w[i]);
        check({tag, " read count"}, nrd, int'(v.len) * 4);
        check({tag, " read addresses"}, addr_bad, 0);
        check({tag, " stable under stall"}, stab_bad, 0);
        step();
        check({tag, " done one cycle"}, done, 0);
        check({tag, " busy after done"}, busy, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        vec_t vecs[3];
        vec_t vc;
        int nv, v1, v2, dc, dn, nacc, acc2, nd, overlap;
        logic [31:0] d1, d2;
        logic b13, b14;
        logic [AW-1:0] la;
        vecs[0] = '{addr: 24'h000000, len: 16'd4, rmask: 16'b1011_0010_1101_0110,
                    w: {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100}};
        vecs[1] = '{addr: 24'hFFFFFE, len: 16'd1, rmask: 16'hFFFF,
                    w: {32'h0, 32'h0, 32'h0, 32'h01001F1E}};
        vecs[2] = '{addr: 24'h000005, len: 16'd2, rmask: 16'h5555,
                    w: {32'h0, 32'h0, 32'h0C0B0A09, 32'h08070605}};
        vc = '{addr: 24'h000004, len: 16'd1, rmask: 16'hFFFF,
               w: {32'h0, 32'h0, 32'h0, 32'h07060504}};

        step();
        step();
        rst = 1'b0;
        check_reset("reset");

        // first-word latency, steady-state spacing and done timing
        req_addr = '0;
        req_len = 16'd2;
        req_valid = 1'b1;
        out_ready = 1'b1;
        nv = 0; v1 = -1; v2 = -1; dc = -1; dn = 0; d1 = '0; d2 = '0; b13 = 0; b14 = 1;
        for (int c = 1; c <= 16; c++) begin
            step();
            req_valid = 1'b0;
            if (out_valid) begin
                nv++;
                if (nv == 1) begin v1 = c; d1 = out_data; end
                else if (nv == 2) begin v2 = c; d2 = out_data; end
            end
            if (done) begin dn++; if (dc < 0) dc = c; end
            if (c == 13) b13 = busy;
            if (c == 14) b14 = busy;
        end
        check("timing first valid cycle", v1, 7);
        check("timing first word", d1, 32'h03020100);
        check("timing second valid cycle", v2, 13);
        check("timing second word", d2, 32'h07060504);
        check("timing valid count", nv, 2);
        check("timing done cycle", dc, 14);
        check("timing done pulses", dn, 1);
        check("timing busy before done", b13, 1);
        check("timing busy at done", b14, 0);
        out_ready = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // zero-length request
        la = mem_addr;
        req_len = '0;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("len0 done next cycle", done, 1);
        check("len0 busy", busy, 0);
        check("len0 mem_addr held", mem_addr, la);
        step();
        check("len0 done one cycle", done, 0);
        check("len0 busy later", busy, 0);
        check("len0 mem_addr held later", mem_addr, la);

        // reset in the middle of a burst, after the first word has been delivered
        req_addr = '0;
        req_len = 16'd4;
        req_valid = 1'b1;
        out_ready = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (9) step();
        check("midburst busy before reset", busy, 1);
        rst = 1'b1;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        check_reset("after midburst reset");
        run_vec(vc, "post-reset");

        // request held high while busy
        req_addr = '0;
        req_len = 16'd1;
        req_valid = 1'b1;
        out_ready = 1'b1;
        nacc = 0; acc2 = -1; nd = 0; overlap = 0;
        for (int c = 0; c < 60 && nd < 2; c++) begin
            if (req_valid && req_ready) begin
                nacc++;
                if (nacc == 2) acc2 = c;
            end
            if (req_ready && busy) overlap++;
            step();
            if (nacc >= 2) req_valid = 1'b0;
            if (done) nd++;
        end
        req_valid = 1'b0;
        check("held req second accept cycle", acc2, 8);
        check("held req done pulses", nd, 2);
        check("held req ready while busy", overlap, 0);
        check("mem_we and mem_din zero", side_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
